iter_divider: RTL and testbench

//  Iterative radix-2 restoring integer divider for the execute stage; the inverse counterpart of the Booth/Wallace multiplier.

---
 rtl/iter_divider.sv | 110 +++++++++++
 tb/tb_iter_divider.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu; define DIV_BYPASS_EN to skip iteration when |dividend| < |divisor|
module iter_divider #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              DivAbleValue,
    input  logic [1:0]        DivMicOperate,
    input  logic [WIDTH-1:0]  Dividend,
    input  logic [WIDTH-1:0]  Divisor,
    input  logic [ADDR_W-1:0] ReDataAddr,
    input  logic              DivFlush,
    output logic              DivReady,
    output logic              ResultAbleValue,
    output logic [WIDTH-1:0]  ResultDate,
    output logic [ADDR_W-1:0] ResultAddr
);
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
    localparam int CW = $clog2(WIDTH);
    state_t            state;
    logic [1:0]        op;
    logic [WIDTH-1:0]  a, b, dvs, rem, quo, a_mag, b_mag, res;
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0]     cnt;
    logic              qneg, rneg, zero, a_neg, b_neg;
    logic [WIDTH:0]    shifted, diff;

    assign DivReady = state == IDLE;

    // operand magnitudes, one restoring step, and the sign-corrected final result
    always_comb begin
        a_neg   = !op[1] && a[WIDTH-1];
        b_neg   = !op[1] && b[WIDTH-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        res     = op[0] ? (zero ? a : (rneg ? -rem : rem))
                        : (zero ? '1 : (qneg ? -quo : quo));
    end

    // control FSM, datapath registers and registered result outputs
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state           <= IDLE;
            ResultAbleValue <= 1'b0;
            ResultDate      <= '0;
            ResultAddr      <= '0;
            op              <= '0;
            a               <= '0;
            b               <= '0;
            addr            <= '0;
            dvs             <= '0;
            rem             <= '0;
            quo             <= '0;
            cnt             <= '0;
            qneg            <= 1'b0;
            rneg            <= 1'b0;
            zero            <= 1'b0;
        end else if (DivFlush) begin
            state           <= IDLE;
            ResultAbleValue <= 1'b0;
        end else begin
            ResultAbleValue <= 1'b0;
            case (state)
                IDLE: if (DivAbleValue) begin
                    state <= PREP;
                    op    <= DivMicOperate;
                    a     <= Dividend;
                    b     <= Divisor;
                    addr  <= ReDataAddr;
                end
                PREP: begin
                    qneg <= a_neg ^ b_neg;
                    rneg <= a_neg;
                    zero <= b == '0;
                    dvs  <= b_mag;
                    rem  <= '0;
                    quo  <= a_mag;
                    cnt  <= CW'(WIDTH - 1);
`ifdef DIV_BYPASS_EN
                    if (b == '0 || a_mag < b_mag) begin
                        state <= FIX;
                        rem   <= a_mag;
                        quo   <= '0;
                    end else begin
                        state <= CALC;
                    end
`else
                    state <= (b == '0) ? FIX : CALC;
`endif
                end
                CALC: begin
                    rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], !diff[WIDTH]};
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    ResultDate      <= res;
                    ResultAddr      <= addr;
                    ResultAbleValue <= 1'b1;
                    state           <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed vectors with a scoreboard queue checked by an output monitor
module tb_iter_divider;
`ifdef DIV_BYPASS_EN
    localparam int SMALL_LAT = 3;
`else
    localparam int SMALL_LAT = 35;
`endif
    logic        Clk = 1'b0, Rest = 1'b0, DivAbleValue = 1'b0, DivFlush = 1'b0;
    logic [1:0]  DivMicOperate = 2'd0;
    logic [31:0] Dividend = '0, Divisor = '0;
    logic [4:0]  ReDataAddr = '0;
    logic        DivReady, ResultAbleValue;
    logic [31:0] ResultDate;
    logic [4:0]  ResultAddr;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0, errors = 0, cyc = 0;

    iter_divider #(.WIDTH(32), .ADDR_W(5)) dut (
        .Clk(Clk), .Rest(Rest), .DivAbleValue(DivAbleValue), .DivMicOperate(DivMicOperate),
        .Dividend(Dividend), .Divisor(Divisor), .ReDataAddr(ReDataAddr), .DivFlush(DivFlush),
        .DivReady(DivReady), .ResultAbleValue(ResultAbleValue), .ResultDate(ResultDate),
        .ResultAddr(ResultAddr)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // latency counts the accept edge as cycle 1
    always @(negedge Clk) begin
        if (ResultAbleValue === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got data %0h addr %0d expected no pulse", ResultDate, ResultAddr);
            end else begin
                mon_e = sb.pop_front();
                chk("data", ResultDate, mon_e.data);
                chk("addr", 32'(ResultAddr), 32'(mon_e.addr));
                chk("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] ad, input logic [31:0] exp, input int lat, input bit push);
        int n = 0;
        while (DivReady !== 1'b1 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (n == 200) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got DivReady %b expected 1", DivReady);
        end
        DivMicOperate = op;
        Dividend      = a;
        Divisor       = b;
        ReDataAddr    = ad;
        DivAbleValue  = 1'b1;
        @(posedge Clk);
        #1;
        DivAbleValue  = 1'b0;
        DivMicOperate = 2'($urandom);
        Dividend      = $urandom;
        Divisor       = $urandom;
        ReDataAddr    = 5'($urandom);
        if (push) sb.push_back('{exp, ad, lat, cyc});
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || DivReady !== 1'b1) && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (n == 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_valid", 32'(ResultAbleValue), 32'd0);
        chk("rst_data", ResultDate, 32'd0);
        chk("rst_addr", 32'(ResultAddr), 32'd0);
        chk("rst_ready", 32'(DivReady), 32'd1);
        Rest = 1'b1;
        @(negedge Clk);
        issue(2'b00, 32'd100,        32'd7,        5'd1,  32'h0000000E, 35, 1'b1);
        issue(2'b01, 32'd100,        32'd7,        5'd2,  32'h00000002, 35, 1'b1);
        issue(2'b00, 32'hFFFFFFF9,   32'd2,        5'd3,  32'hFFFFFFFD, 35, 1'b1);
        issue(2'b01, 32'hFFFFFFF9,   32'd2,        5'd4,  32'hFFFFFFFF, 35, 1'b1);
        issue(2'b10, 32'hFFFFFFFF,   32'd2,        5'd5,  32'h7FFFFFFF, 35, 1'b1);
        issue(2'b11, 32'hFFFFFFFF,   32'd2,        5'd6,  32'h00000001, 35, 1'b1);
        issue(2'b00, 32'h80000000,   32'hFFFFFFFF, 5'd7,  32'h80000000, 35, 1'b1);
        issue(2'b01, 32'h80000000,   32'hFFFFFFFF, 5'd8,  32'h00000000, 35, 1'b1);
        issue(2'b00, 32'd5,          32'd0,        5'd9,  32'hFFFFFFFF, 3,  1'b1);
        issue(2'b11, 32'd5,          32'd0,        5'd10, 32'h00000005, 3,  1'b1);
        issue(2'b01, 32'hFFFFFFF7,   32'd0,        5'd11, 32'hFFFFFFF7, 3,  1'b1);
        issue(2'b00, 32'd7,          32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, 35, 1'b1);
        issue(2'b01, 32'd7,          32'hFFFFFFFE, 5'd13, 32'h00000001, 35, 1'b1);
        issue(2'b10, 32'h80000000,   32'h00000010, 5'd14, 32'h08000000, 35, 1'b1);
        issue(2'b00, 32'd3,          32'd10,       5'd15, 32'h00000000, SMALL_LAT, 1'b1);
        issue(2'b01, 32'hFFFFFFFD,   32'd10,       5'd16, 32'hFFFFFFFD, SMALL_LAT, 1'b1);
        drain();
        issue(2'b00, 32'd1000, 32'd3, 5'd20, 32'd0, 0, 1'b0);
        repeat (11) @(negedge Clk);
        DivFlush = 1'b1;
        @(posedge Clk);
        #1;
        DivFlush = 1'b0;
        chk("flush_ready", 32'(DivReady), 32'd1);
        issue(2'b00, 32'd100, 32'd7, 5'd21, 32'h0000000E, 35, 1'b1);
        drain();
        DivAbleValue  = 1'b1;
        DivFlush      = 1'b1;
        DivMicOperate = 2'b00;
        Dividend      = 32'd9;
        Divisor       = 32'd3;
        ReDataAddr    = 5'd22;
        @(posedge Clk);
        #1;
        DivAbleValue = 1'b0;
        DivFlush     = 1'b0;
        chk("flush_wins", 32'(DivReady), 32'd1);
        repeat (5) @(negedge Clk);
        issue(2'b00, 32'd100, 32'd7, 5'd23, 32'd0, 0, 1'b0);
        repeat (8) @(negedge Clk);
        #2;
        Rest = 1'b0;
        #1;
        chk("arst_valid", 32'(ResultAbleValue), 32'd0);
        chk("arst_data", ResultDate, 32'd0);
        chk("arst_addr", 32'(ResultAddr), 32'd0);
        chk("arst_ready", 32'(DivReady), 32'd1);
        @(negedge Clk);
        Rest = 1'b1;
        @(negedge Clk);
        issue(2'b01, 32'd100, 32'd7, 5'd24, 32'h00000002, 35, 1'b1);
        drain();
        repeat (40) @(negedge Clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
